fetch_pc_unit: RTL and testbench

FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

---
 rtl/fetch_pc_unit_pkg.sv | 21 ++
 rtl/fetch_wait_counter.sv | 43 ++++
 rtl/fetch_pc_unit.sv | 122 ++++++++++++
 tb/tb_fetch_pc_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the fetch PC unit: state encoding, word size,
// default memory geometry and the address wrap helper.
package fetch_pc_unit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  localparam int WORD_BYTES        = 4;
  localparam int DEFAULT_MEM_WORDS = 1024;
  localparam int DEFAULT_MEM_WAIT  = 4;

  // Byte address folded into the instruction memory window.
  function automatic logic [31:0] wrap_addr(input logic [31:0] addr,
                                            input logic [31:0] mem_bytes);
    return addr % mem_bytes;
  endfunction

endpackage

// File: rtl/fetch_wait_counter.sv
// Settle counter for instruction memory: counts cycles since the address
// was issued and flags the last settle cycle.
module fetch_wait_counter
  import fetch_pc_unit_pkg::*;
#(
  parameter int MEM_WAIT = DEFAULT_MEM_WAIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       en_i,
  output logic [3:0] count_o,
  output logic       tc_o
);

  localparam logic [3:0] TC_VAL = 4'(MEM_WAIT - 1);

  logic [3:0] count_q;
  logic [3:0] count_d;

  // Clear wins over enable; otherwise count up or hold.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = 4'd0;
    end else if (en_i) begin
      count_d = count_q + 4'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = (count_q == TC_VAL);

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction fetch PC sequencer. Issues pc_q to instruction memory, waits
// MEM_WAIT cycles for the data to settle, registers it and presents it to
// decode until accepted; redirects restart fetch at a new target.
//
// Handshake: instr_valid/instr_out/instr_pc form a valid/ready channel.
// Once instr_valid is high the payload is held unchanged until a cycle with
// instr_ready high (transfer) or redirect high (payload dropped). instr_ready
// while instr_valid is low is ignored.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = DEFAULT_MEM_WORDS,
  parameter int          MEM_WAIT  = DEFAULT_MEM_WAIT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  instr_in,
  input  logic         instr_ready,
  input  logic         redirect,
  input  logic [31:0]  redirect_pc,
  output logic [31:0]  mem_addr,
  output logic [31:0]  instr_out,
  output logic [31:0]  instr_pc,
  output logic         instr_valid,
  output fetch_state_e dbg_state,
  output logic [3:0]   dbg_count
);

  localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * WORD_BYTES);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_out_q, instr_out_d;
  logic [31:0]  instr_pc_q, instr_pc_d;
  logic         valid_q, valid_d;
  logic         cnt_en;
  logic         cnt_tc;
  logic [31:0]  next_pc;
  logic [31:0]  redirect_target;

  assign next_pc         = wrap_addr(pc_q + 32'd4, MEM_BYTES);
  assign redirect_target = wrap_addr(redirect_pc, MEM_BYTES) & 32'hFFFF_FFFC;

  // Counter only runs while a fetch is settling; every other path restarts it.
  fetch_wait_counter #(
    .MEM_WAIT(MEM_WAIT)
  ) u_wait (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (!cnt_en),
    .en_i   (cnt_en),
    .count_o(dbg_count),
    .tc_o   (cnt_tc)
  );

  // Next-state and datapath selection; redirect outranks capture and accept.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_out_d = instr_out_q;
    instr_pc_d  = instr_pc_q;
    valid_d     = valid_q;
    cnt_en      = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (redirect) begin
          pc_d    = redirect_target;
          valid_d = 1'b0;
        end else if (cnt_tc) begin
          instr_out_d = instr_in;
          instr_pc_d  = pc_q;
          valid_d     = 1'b1;
          state_d     = HOLD;
        end else begin
          cnt_en = 1'b1;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_d    = redirect_target;
          valid_d = 1'b0;
          state_d = FETCH;
        end else if (instr_ready) begin
          pc_d    = next_pc;
          valid_d = 1'b0;
          state_d = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      instr_out_q <= 32'd0;
      instr_pc_q  <= 32'd0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_out_q <= instr_out_d;
      instr_pc_q  <= instr_pc_d;
      valid_q     <= valid_d;
    end
  end

  assign mem_addr    = pc_q;
  assign instr_out   = instr_out_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = valid_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit with a small instruction memory model
// answering mem_addr.
module tb_fetch_pc_unit;
  import fetch_pc_unit_pkg::*;

  localparam int MW = 4;

  logic         clk;
  logic         rst_n;
  logic [31:0]  instr_in;
  logic         instr_ready;
  logic         redirect;
  logic [31:0]  redirect_pc;
  logic [31:0]  mem_addr;
  logic [31:0]  instr_out;
  logic [31:0]  instr_pc;
  logic         instr_valid;
  fetch_state_e dbg_state;
  logic [3:0]   dbg_count;

  int total = 0;
  int bad   = 0;

  logic [31:0] imem [0:1023];

  // Clock and instruction memory.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 1024; i++) imem[i] = 32'h5A00_0000 + 32'(i * 4);
  end
  assign instr_in = imem[mem_addr[11:2]];

  fetch_pc_unit #(
    .RESET_PC (32'h0000_0000),
    .MEM_WORDS(1024),
    .MEM_WAIT (MW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr_in   (instr_in),
    .instr_ready(instr_ready),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .mem_addr   (mem_addr),
    .instr_out  (instr_out),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .dbg_state  (dbg_state),
    .dbg_count  (dbg_count)
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'h5A00_0000 + a;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until instr_valid is seen; n is the number of edges, -1 on timeout.
  task automatic wait_valid(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (instr_valid) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    step(); step();
    total++; if (mem_addr !== 32'd0) begin bad++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr); end
    total++; if (instr_out !== 32'd0) begin bad++; $display("FAIL rst_instr_out got=%h exp=0", instr_out); end
    total++; if (instr_pc !== 32'd0) begin bad++; $display("FAIL rst_instr_pc got=%h exp=0", instr_pc); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", instr_valid); end
    total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL rst_state got=%0d exp=0", dbg_state); end
    total++; if (dbg_count !== 4'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", dbg_count); end
  endtask

  task automatic test_sequential();
    int n;
    rst_n = 1'b1; instr_ready = 1'b1;
    wait_valid(n);
    total++; if (n != 1 + MW) begin bad++; $display("FAIL first_latency got=%0d exp=%0d", n, 1 + MW); end
    total++; if (instr_pc !== 32'd0) begin bad++; $display("FAIL seq_pc0 got=%h exp=0", instr_pc); end
    total++; if (instr_out !== word_at(32'd0)) begin bad++; $display("FAIL seq_word0 got=%h exp=%h", instr_out, word_at(32'd0)); end
    for (int k = 1; k <= 2; k++) begin
      step();
      total++; if (mem_addr !== 32'(4 * k) || instr_valid !== 1'b0) begin
        bad++; $display("FAIL seq_addr got=%h/%b exp=%h/0", mem_addr, instr_valid, 32'(4 * k));
      end
      wait_valid(n);
      total++; if (n != MW) begin bad++; $display("FAIL seq_latency got=%0d exp=%0d", n, MW); end
      total++; if (instr_pc !== 32'(4 * k) || instr_out !== word_at(32'(4 * k))) begin
        bad++; $display("FAIL seq_payload got=%h/%h exp=%h/%h", instr_pc, instr_out, 32'(4 * k), word_at(32'(4 * k)));
      end
    end
  endtask

  task automatic test_hold();
    int n;
    instr_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      total++;
      if (instr_pc !== 32'd8 || instr_out !== word_at(32'd8) || mem_addr !== 32'd8 || instr_valid !== 1'b1) begin
        bad++; $display("FAIL hold_stable got=%h/%h/%h/%b exp=8/%h/8/1", instr_pc, instr_out, mem_addr, instr_valid, word_at(32'd8));
      end
    end
    instr_ready = 1'b1;
    step();
    total++; if (mem_addr !== 32'd12) begin bad++; $display("FAIL hold_release_addr got=%h exp=c", mem_addr); end
    wait_valid(n);
    total++; if (n != MW || instr_pc !== 32'd12) begin bad++; $display("FAIL hold_next got=%0d/%h exp=%0d/c", n, instr_pc, MW); end
  endtask

  task automatic test_redirect_fetch();
    int n;
    rst_n = 1'b0; step(); rst_n = 1'b1;
    wait_valid(n);
    step(); step();
    total++; if (mem_addr !== 32'd4 || dbg_state !== FETCH) begin bad++; $display("FAIL rdf_setup got=%h/%0d exp=4/1", mem_addr, dbg_state); end
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    step();
    redirect = 1'b0;
    total++; if (mem_addr !== 32'h100 || instr_valid !== 1'b0) begin bad++; $display("FAIL rdf_addr got=%h/%b exp=100/0", mem_addr, instr_valid); end
    wait_valid(n);
    total++; if (n != MW || instr_pc !== 32'h100) begin bad++; $display("FAIL rdf_first_valid got=%0d/%h exp=%0d/100", n, instr_pc, MW); end
    // Redirect on the terminal settle cycle must suppress the capture.
    step(); step(); step(); step();
    total++; if (mem_addr !== 32'h104 || dbg_count !== 4'(MW - 1)) begin bad++; $display("FAIL rdf_tc_setup got=%h/%0d exp=104/%0d", mem_addr, dbg_count, MW - 1); end
    redirect = 1'b1; redirect_pc = 32'h0000_0040;
    step();
    redirect = 1'b0;
    total++; if (instr_valid !== 1'b0 || mem_addr !== 32'h40) begin bad++; $display("FAIL rdf_tc got=%b/%h exp=0/40", instr_valid, mem_addr); end
    wait_valid(n);
    total++; if (n != MW || instr_pc !== 32'h40) begin bad++; $display("FAIL rdf_tc_valid got=%0d/%h exp=%0d/40", n, instr_pc, MW); end
  endtask

  task automatic test_redirect_hold();
    int n;
    instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0200;
    step();
    redirect = 1'b0;
    total++; if (mem_addr !== 32'h200 || instr_valid !== 1'b0) begin bad++; $display("FAIL rdh_addr got=%h/%b exp=200/0", mem_addr, instr_valid); end
    wait_valid(n);
    total++; if (n != MW || instr_pc !== 32'h200 || instr_out !== word_at(32'h200)) begin
      bad++; $display("FAIL rdh_valid got=%0d/%h/%h exp=%0d/200/%h", n, instr_pc, instr_out, MW, word_at(32'h200));
    end
  endtask

  task automatic test_wrap();
    int n;
    redirect = 1'b1; redirect_pc = 32'h0000_0FFC;
    step();
    redirect = 1'b0;
    total++; if (mem_addr !== 32'hFFC) begin bad++; $display("FAIL wrap_setup got=%h exp=ffc", mem_addr); end
    wait_valid(n);
    total++; if (instr_pc !== 32'hFFC || instr_out !== word_at(32'hFFC)) begin bad++; $display("FAIL wrap_payload got=%h/%h exp=ffc/%h", instr_pc, instr_out, word_at(32'hFFC)); end
    step();
    total++; if (mem_addr !== 32'd0) begin bad++; $display("FAIL wrap_next got=%h exp=0", mem_addr); end
    redirect = 1'b1; redirect_pc = 32'h0000_1008;
    step();
    redirect = 1'b0;
    total++; if (mem_addr !== 32'h8) begin bad++; $display("FAIL wrap_redirect got=%h exp=8", mem_addr); end
    wait_valid(n);
    total++; if (instr_pc !== 32'h8) begin bad++; $display("FAIL wrap_redirect_valid got=%h exp=8", instr_pc); end
  endtask

  task automatic test_reset_midfetch();
    int n;
    step(); step();
    total++; if (dbg_state !== FETCH || mem_addr !== 32'hC) begin bad++; $display("FAIL rmf_setup got=%0d/%h exp=1/c", dbg_state, mem_addr); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (mem_addr !== 32'd0 || instr_pc !== 32'd0 || instr_out !== 32'd0) begin
      bad++; $display("FAIL rmf_async_data got=%h/%h/%h exp=0/0/0", mem_addr, instr_pc, instr_out);
    end
    total++; if (instr_valid !== 1'b0 || dbg_state !== IDLE || dbg_count !== 4'd0) begin
      bad++; $display("FAIL rmf_async_ctrl got=%b/%0d/%0d exp=0/0/0", instr_valid, dbg_state, dbg_count);
    end
    step();
    rst_n = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0300;
    step();
    redirect = 1'b0;
    total++; if (dbg_state !== FETCH || mem_addr !== 32'd0) begin bad++; $display("FAIL rmf_idle_ignore got=%0d/%h exp=1/0", dbg_state, mem_addr); end
    wait_valid(n);
    total++; if (n + 1 != 1 + MW || instr_pc !== 32'd0) begin bad++; $display("FAIL rmf_latency got=%0d/%h exp=%0d/0", n + 1, instr_pc, 1 + MW); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_hold();
    test_redirect_fetch();
    test_redirect_hold();
    test_wrap();
    test_reset_midfetch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
